// File: rtl/sample_accumulator_if.sv
// Sample stream in, window-sum stream out, plus fill status.
// slave is the accumulator side; master is the producer/consumer side.
interface sample_accumulator_if #(
    parameter int DIV_LOG2     = 3,
    parameter int SAMPLE_WIDTH = 32,
    parameter int SUM_WIDTH    = SAMPLE_WIDTH + DIV_LOG2
);
    logic [SAMPLE_WIDTH-1:0] din;
    logic                    din_valid;
    logic                    din_ready;
    logic                    flush;
    logic [SUM_WIDTH-1:0]    dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [DIV_LOG2-1:0]     fill_count;

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output din_ready, dout, dout_valid, fill_count
    );

    modport master (
        output din, din_valid, flush, dout_ready,
        input  din_ready, dout, dout_valid, fill_count
    );
endinterface

// File: rtl/sample_accumulator.sv
// Sums windows of 2^DIV_LOG2 unsigned samples and hands each sum downstream
// through a one-entry valid/ready output register.
module sample_accumulator #(
    parameter int DIV_LOG2     = 3,
    parameter int SAMPLE_WIDTH = 32,
    parameter int SUM_WIDTH    = SAMPLE_WIDTH + DIV_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    sample_accumulator_if.slave   bus
);
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] sum_next;
    logic                 last;
    logic                 in_hs;
    logic                 out_hs;

    assign last     = &bus.fill_count;
    assign sum_next = acc + SUM_WIDTH'(bus.din);

    // Only the window-closing sample has to wait for the output slot.
    assign bus.din_ready = !reset && !bus.flush &&
                           (!last || !bus.dout_valid || bus.dout_ready);
    assign in_hs  = bus.din_valid && bus.din_ready;
    assign out_hs = bus.dout_valid && bus.dout_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            bus.fill_count <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            if (bus.flush) begin
                acc            <= '0;
                bus.fill_count <= '0;
            end else if (in_hs) begin
                if (last) begin
                    acc            <= '0;
                    bus.fill_count <= '0;
                    bus.dout       <= sum_next;
                end else begin
                    acc            <= sum_next;
                    bus.fill_count <= bus.fill_count + DIV_LOG2'(1);
                end
            end
            // A new sum landing on the delivery cycle keeps valid high.
            if (in_hs && last)
                bus.dout_valid <= 1'b1;
            else if (out_hs)
                bus.dout_valid <= 1'b0;
        end
    end
endmodule

// File: doc/sample_accumulator.md
SAMPLE_ACCUMULATOR -- requirements
Module: sample_accumulator

Interface
REQ-001 The block SHALL have parameter DIV_LOG2, default 3: log2 of the samples per window (N = 2^DIV_LOG2), legal range 1..8.
REQ-002 The block SHALL have parameter SAMPLE_WIDTH, default 32: unsigned input sample width.
REQ-003 The block SHALL have parameter SUM_WIDTH, default SAMPLE_WIDTH+DIV_LOG2: output sum width, matching the input width of the downstream rounding divider.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port din, input, SAMPLE_WIDTH: unsigned sample.
REQ-007 Port din_valid, input, 1: din is valid this cycle.
REQ-008 Port din_ready, output, 1: block accepts din this cycle.
REQ-009 Port flush, input, 1: discard the partial window.
REQ-010 Port dout, output, SUM_WIDTH: sum of one complete window of N samples.
REQ-011 Port dout_valid, output, 1: dout holds an undelivered window sum.
REQ-012 Port dout_ready, input, 1: downstream consumes dout this cycle.
REQ-013 Port fill_count, output, DIV_LOG2: samples accepted in the current partial window.

Function
REQ-014 Input handshake SHALL occur on any cycle with din_valid=1 and din_ready=1; output handshake SHALL occur on any cycle with dout_valid=1 and dout_ready=1.
REQ-015 The accumulator SHALL be SUM_WIDTH bits, unsigned, with zero-extended samples; no overflow is possible, so no saturation logic is present.
REQ-016 On an input handshake with fill_count < N-1, the block SHALL add din to the accumulator and increment fill_count.
REQ-017 On an input handshake with fill_count = N-1 (final sample), the block SHALL load dout with accumulator+din, set dout_valid, clear the accumulator, and wrap fill_count to 0, all on the same edge.
REQ-018 Output latency SHALL be one cycle: dout_valid rises on the cycle after the final sample is accepted.
REQ-019 din_ready SHALL be combinational: 1 when fill_count != N-1, when dout_valid=0, or when dout_ready=1; otherwise 0 (final sample stalls behind an undelivered sum).
REQ-020 Non-final samples SHALL be accepted regardless of output backpressure.
REQ-021 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-022 An output handshake without a simultaneous final-sample handshake SHALL clear dout_valid on the next edge.
REQ-023 A simultaneous output handshake and final-sample handshake SHALL load the new sum with dout_valid remaining 1, with no bubble.
REQ-024 flush=1 SHALL clear the accumulator and fill_count on the next edge, and SHALL force din_ready=0 that cycle; dout/dout_valid are unaffected and output handshakes proceed normally.
REQ-025 dout_ready SHALL be ignored when dout_valid=0.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set the accumulator=0, fill_count=0, dout=0, and dout_valid=0, with priority over all other inputs.
REQ-027 During reset, din_ready SHALL be 0.
REQ-028 Reset asserted mid-window or with a pending sum SHALL discard both, with no output handshake delivered.

Verification
REQ-029 Scenario: N=8, dout_ready=1, samples 1..8 back-to-back -> dout=36, dout_valid high for one cycle, 1 cycle after the 8th accept.
REQ-030 Scenario: 8 samples of 0xFFFFFFFF (SAMPLE_WIDTH=32) -> dout=0x7FFFFFFF8, no wrap.
REQ-031 Scenario: dout_ready=0, 16 samples of 5 offered continuously -> first dout=40 held; samples 9-15 accepted, din_ready=0 on the 16th until dout_ready=1; the next sum is 40 and arrives with no bubble.
REQ-032 Scenario: 3 samples of 7, flush, then 8 samples of 2 -> dout=16, fill_count=0 after flush.
REQ-033 Scenario: reset pulsed after 5 samples with a sum pending -> dout_valid=0, fill_count=0, and the next full window sums only post-reset samples.
REQ-034 Scenario: random din_valid/dout_ready over 10k samples -> every dout equals the reference sum of consecutive 8-sample groups, none dropped or duplicated.
